decode_hazard_ctrl: RTL

//  Hazard/sequencing controller for the decode stage. Shadows the destinations of in-flight instructions in E/M/W.

---
 rtl/decode_hazard_ctrl_pkg.sv | 27 ++
 rtl/hz_fwd_sel.sv | 26 ++
 rtl/decode_hazard_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/decode_hazard_ctrl_pkg.sv
// rtl/decode_hazard_ctrl_pkg.sv - shared types for the decode hazard controller
package decode_hazard_ctrl_pkg;

  typedef logic [4:0] creg_addr_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t rd;
    logic       wen;
    logic       load;
  } hz_slot_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_t;

  localparam hz_slot_t HZ_BUBBLE = '0;

  // x0 is hardwired zero, so it never produces a dependency
  function automatic logic slot_match(hz_slot_t s, creg_addr_t rs, logic use_rs);
    return s.valid & s.wen & (s.rd == rs) & (rs != '0) & use_rs;
  endfunction

endpackage

// File: rtl/hz_fwd_sel.sv
// rtl/hz_fwd_sel.sv - operand forwarding select, youngest in-flight producer wins
module hz_fwd_sel
  import decode_hazard_ctrl_pkg::*;
(
  input  hz_slot_t   e_slot,
  input  hz_slot_t   m_slot,
  input  hz_slot_t   w_slot,
  input  creg_addr_t rs,
  input  logic       use_rs,
  output fwd_sel_t   sel
);

  logic unused_load;
  assign unused_load = e_slot.load ^ m_slot.load ^ w_slot.load;

  always_comb begin
    sel = FWD_REG;
    if (slot_match(e_slot, rs, use_rs))
      sel = FWD_E;
    else if (slot_match(m_slot, rs, use_rs))
      sel = FWD_M;
    else if (slot_match(w_slot, rs, use_rs))
      sel = FWD_W;
  end

endmodule

// File: rtl/decode_hazard_ctrl.sv
// rtl/decode_hazard_ctrl.sv - decode-stage stall/flush/forward control from E/M/W shadow slots
// Optional stall-cycle perf counters with DECODE_HZD_PERF_EN.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = 4
`ifdef DECODE_HZD_PERF_EN
  ,
  parameter int CNT_W  = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic [4:0] d_rs1,
  input  logic [4:0] d_rs2,
  input  logic       d_use_rs1,
  input  logic       d_use_rs2,
  input  logic [4:0] d_rd,
  input  logic       d_wen,
  input  logic       d_is_load,
  input  logic       d_is_md,
  input  logic       mem_stall,
  input  logic       redirect,
  output logic       stall_f,
  output logic       stall_d,
  output logic       bubble_e,
  output logic       flush_d,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       md_busy
`ifdef DECODE_HZD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_ldu,
  output logic [CNT_W-1:0] perf_md
`endif
);

  localparam int MD_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LAT - 1);

  hz_slot_t        e_q, m_q, w_q, e_d, m_d, w_d, dec_slot;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;
  fwd_sel_t        sel_a, sel_b;
  logic            busy, ld_use;

  assign dec_slot = '{valid: d_valid, rd: d_rd, wen: d_wen, load: d_is_load};
  assign busy     = (md_cnt_q != '0);
  assign ld_use   = d_valid & e_q.load &
                    (slot_match(e_q, d_rs1, d_use_rs1) | slot_match(e_q, d_rs2, d_use_rs2));

  hz_fwd_sel u_fwd_a (.e_slot(e_q), .m_slot(m_q), .w_slot(w_q), .rs(d_rs1), .use_rs(d_use_rs1), .sel(sel_a));
  hz_fwd_sel u_fwd_b (.e_slot(e_q), .m_slot(m_q), .w_slot(w_q), .rs(d_rs2), .use_rs(d_use_rs2), .sel(sel_b));

  assign fwd_a   = reset ? sel_a : FWD_REG;
  assign fwd_b   = reset ? sel_b : FWD_REG;
  assign md_busy = reset & busy;

  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    bubble_e = 1'b0;
    flush_d  = 1'b0;
    e_d      = e_q;
    m_d      = m_q;
    w_d      = w_q;
    md_cnt_d = md_cnt_q;
    if (!reset) begin
      md_cnt_d = '0;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (redirect) begin
      // the squashed decode op never issues, so its mul/div wait is dropped
      flush_d  = 1'b1;
      bubble_e = 1'b1;
      e_d      = HZ_BUBBLE;
      m_d      = e_q;
      w_d      = m_q;
      md_cnt_d = '0;
    end else if (busy) begin
      // mul/div keeps occupying EX; downstream drains behind it
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      m_d      = HZ_BUBBLE;
      w_d      = m_q;
      md_cnt_d = md_cnt_q - MD_W'(1);
    end else if (ld_use) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_e = 1'b1;
      e_d      = HZ_BUBBLE;
      m_d      = e_q;
      w_d      = m_q;
    end else begin
      e_d = dec_slot;
      m_d = e_q;
      w_d = m_q;
      if (d_valid & d_is_md)
        md_cnt_d = MD_INIT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q      <= HZ_BUBBLE;
      m_q      <= HZ_BUBBLE;
      w_q      <= HZ_BUBBLE;
      md_cnt_q <= '0;
    end else begin
      e_q      <= e_d;
      m_q      <= m_d;
      w_q      <= w_d;
      md_cnt_q <= md_cnt_d;
    end
  end

`ifdef DECODE_HZD_PERF_EN
  logic ldu_cyc;
  assign ldu_cyc = ~mem_stall & ~redirect & ~busy & ld_use;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ldu <= '0;
      perf_md  <= '0;
    end else begin
      if (ldu_cyc)
        perf_ldu <= perf_ldu + CNT_W'(1);
      if (busy & ~mem_stall)
        perf_md <= perf_md + CNT_W'(1);
    end
  end
`endif

endmodule
